// File: rtl/punc_controller.sv
// punc_controller: control FSM for the PUnC LC3 processor.
// Sequences fetch / decode / execute and drives every datapath select,
// load and enable combinationally from the FSM state and the IR.
// Optional build macro: PUNC_RESERVED_HALT_EN -- when defined, the reserved
// opcodes 1000 (RTI) and 1101 halt from DECODE; otherwise they run as NOPs.
module punc_controller (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ir,
   input  logic        nzp_match,
   output logic        pc_ld,
   output logic        pc_clr,
   output logic        pc_inc,
   output logic [1:0]  pc_sel,
   output logic        ir_ld,
   output logic        ir_clr,
   output logic        dmem_rd,
   output logic        dmem_wr,
   output logic [1:0]  dmem_r_addr_sel,
   output logic [1:0]  dmem_w_addr_sel,
   output logic [1:0]  rf_w_data_sel,
   output logic        rf_w_addr_sel,
   output logic        rf_w_wr,
   output logic [1:0]  rf_rp_addr_sel,
   output logic        rf_rp_rd,
   output logic        rf_rq_rd,
   output logic        temp_ld,
   output logic        nzp_ld,
   output logic        nzp_clr,
   output logic [1:0]  alu_sel,
   output logic        alu_in_a_sel,
   output logic        halted,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_EXEC2  = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_RTI  = 4'b1000;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_RES  = 4'b1101;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   state_t     state, state_next;
   logic [3:0] opcode;
   logic       unused_ir;

   assign opcode    = ir[15:12];
   // Register fields are decoded in the datapath; only opcode, ir[11] and ir[5] matter here.
   assign unused_ir = ^{ir[10:6], ir[4:0]};
   assign state_dbg = state;

   // FSM state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) state <= S_INIT;
      else      state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      unique case (state)
         S_INIT:   state_next = S_FETCH;
         S_FETCH:  state_next = S_DECODE;
         S_DECODE: begin
            state_next = S_EXEC;
            if (opcode == OP_TRAP) state_next = S_HALT;
`ifdef PUNC_RESERVED_HALT_EN
            if (opcode == OP_RTI || opcode == OP_RES) state_next = S_HALT;
`endif
         end
         S_EXEC: begin
            if (opcode == OP_LDI || opcode == OP_STI) state_next = S_EXEC2;
            else                                     state_next = S_FETCH;
         end
         S_EXEC2:  state_next = S_FETCH;
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_INIT;
      endcase
   end

   // Output decode from state and opcode; everything defaults to inactive.
   always_comb begin
      pc_ld           = 1'b0;
      pc_clr          = 1'b0;
      pc_inc          = 1'b0;
      pc_sel          = 2'd0;
      ir_ld           = 1'b0;
      ir_clr          = 1'b0;
      dmem_rd         = 1'b0;
      dmem_wr         = 1'b0;
      dmem_r_addr_sel = 2'd0;
      dmem_w_addr_sel = 2'd0;
      rf_w_data_sel   = 2'd0;
      rf_w_addr_sel   = 1'b0;
      rf_w_wr         = 1'b0;
      rf_rp_addr_sel  = 2'd0;
      rf_rp_rd        = 1'b0;
      rf_rq_rd        = 1'b0;
      temp_ld         = 1'b0;
      nzp_ld          = 1'b0;
      nzp_clr         = 1'b0;
      alu_sel         = 2'd0;
      alu_in_a_sel    = 1'b0;
      halted          = 1'b0;
      unique case (state)
         S_INIT: begin
            pc_clr  = 1'b1;
            ir_clr  = 1'b1;
            nzp_clr = 1'b1;
         end
         S_FETCH: begin
            dmem_rd         = 1'b1;
            dmem_r_addr_sel = 2'd0;
            ir_ld           = 1'b1;
            pc_inc          = 1'b1;
         end
         S_DECODE: ;
         S_EXEC: begin
            unique case (opcode)
               OP_ADD, OP_AND: begin
                  rf_rp_addr_sel = 2'd2;
                  alu_in_a_sel   = ir[5];
                  alu_sel        = (opcode == OP_AND) ? 2'd1 : 2'd0;
                  rf_w_wr        = 1'b1;
                  rf_w_data_sel  = 2'd0;
                  nzp_ld         = 1'b1;
               end
               OP_NOT: begin
                  alu_sel       = 2'd2;
                  rf_w_wr       = 1'b1;
                  rf_w_data_sel = 2'd0;
                  nzp_ld        = 1'b1;
               end
               OP_LD, OP_LDR: begin
                  dmem_rd         = 1'b1;
                  dmem_r_addr_sel = (opcode == OP_LDR) ? 2'd2 : 2'd1;
                  rf_w_data_sel   = 2'd1;
                  rf_w_wr         = 1'b1;
                  nzp_ld          = 1'b1;
               end
               OP_LEA: begin
                  rf_w_data_sel = 2'd3;
                  rf_w_wr       = 1'b1;
                  nzp_ld        = 1'b1;
               end
               OP_LDI, OP_STI: begin
                  dmem_rd         = 1'b1;
                  dmem_r_addr_sel = 2'd1;
                  temp_ld         = 1'b1;
               end
               OP_ST, OP_STR: begin
                  rf_rp_addr_sel  = 2'd0;
                  dmem_wr         = 1'b1;
                  dmem_w_addr_sel = (opcode == OP_STR) ? 2'd1 : 2'd0;
               end
               OP_BR: begin
                  pc_ld  = nzp_match;
                  pc_sel = 2'd0;
               end
               OP_JMP: begin
                  rf_rp_addr_sel = 2'd1;
                  pc_ld          = 1'b1;
                  pc_sel         = 2'd2;
               end
               OP_JSR: begin
                  rf_w_addr_sel = 1'b1;
                  rf_w_data_sel = 2'd2;
                  rf_w_wr       = 1'b1;
                  pc_ld         = 1'b1;
                  if (ir[11]) begin
                     pc_sel = 2'd1;
                  end else begin
                     pc_sel         = 2'd2;
                     rf_rp_addr_sel = 2'd1;
                  end
               end
               default: ;  // RTI, reserved and TRAP: no strobes
            endcase
         end
         S_EXEC2: begin
            if (opcode == OP_LDI) begin
               dmem_rd         = 1'b1;
               dmem_r_addr_sel = 2'd3;
               rf_w_data_sel   = 2'd1;
               rf_w_wr         = 1'b1;
               nzp_ld          = 1'b1;
            end else if (opcode == OP_STI) begin
               rf_rp_addr_sel  = 2'd0;
               dmem_wr         = 1'b1;
               dmem_w_addr_sel = 2'd2;
            end
         end
         S_HALT: halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_punc_controller.sv
// tb_punc_controller: directed-vector bench for punc_controller.
module tb_punc_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ir;
   logic        nzp_match;
   logic        pc_ld, pc_clr, pc_inc;
   logic [1:0]  pc_sel;
   logic        ir_ld, ir_clr, dmem_rd, dmem_wr;
   logic [1:0]  dmem_r_addr_sel, dmem_w_addr_sel, rf_w_data_sel;
   logic        rf_w_addr_sel, rf_w_wr;
   logic [1:0]  rf_rp_addr_sel;
   logic        rf_rp_rd, rf_rq_rd, temp_ld, nzp_ld, nzp_clr;
   logic [1:0]  alu_sel;
   logic        alu_in_a_sel, halted;
   logic [2:0]  state_dbg;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   punc_controller dut (
      .clk(clk), .rst(rst), .ir(ir), .nzp_match(nzp_match),
      .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_sel(pc_sel),
      .ir_ld(ir_ld), .ir_clr(ir_clr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
      .dmem_r_addr_sel(dmem_r_addr_sel), .dmem_w_addr_sel(dmem_w_addr_sel),
      .rf_w_data_sel(rf_w_data_sel), .rf_w_addr_sel(rf_w_addr_sel),
      .rf_w_wr(rf_w_wr), .rf_rp_addr_sel(rf_rp_addr_sel),
      .rf_rp_rd(rf_rp_rd), .rf_rq_rd(rf_rq_rd), .temp_ld(temp_ld),
      .nzp_ld(nzp_ld), .nzp_clr(nzp_clr), .alu_sel(alu_sel),
      .alu_in_a_sel(alu_in_a_sel), .halted(halted), .state_dbg(state_dbg)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One posedge, then sample at the following negedge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // From a sampled FETCH, present the instruction and advance to EXEC (or HALT).
   task automatic to_exec(input logic [15:0] instr);
      ir = instr;
      tick();
      check("decode_state", 16'(state_dbg), 16'd2);
      check("decode_wr", 16'({rf_w_wr, dmem_wr, pc_ld, dmem_rd}), 16'd0);
      tick();
   endtask

   initial begin
      rst = 1'b0; ir = 16'h0000; nzp_match = 1'b0;
      @(negedge clk);
      tick(); tick();
      // Reset / INIT
      check("init_state", 16'(state_dbg), 16'd0);
      check("init_clr", 16'({pc_clr, ir_clr, nzp_clr}), 16'b111);
      check("init_halted", 16'(halted), 16'd0);
      check("init_rd", 16'(dmem_rd), 16'd0);
      rst = 1'b1;
      tick();
      check("fetch_state", 16'(state_dbg), 16'd1);
      check("fetch_strobes", 16'({dmem_rd, ir_ld, pc_inc}), 16'b111);
      check("fetch_raddr", 16'(dmem_r_addr_sel), 16'd0);

      // ADD R1,R1,#5
      to_exec(16'h1265);
      check("add_state", 16'(state_dbg), 16'd3);
      check("add_imm_sel", 16'(alu_in_a_sel), 16'd1);
      check("add_alu", 16'(alu_sel), 16'd0);
      check("add_wr_nzp", 16'({rf_w_wr, nzp_ld}), 16'b11);
      check("add_wdata", 16'(rf_w_data_sel), 16'd0);
      check("add_rp", 16'(rf_rp_addr_sel), 16'd2);
      tick();
      check("add_back_fetch", 16'(state_dbg), 16'd1);

      // AND R0,R1,R2 (register form)
      to_exec(16'h5042);
      check("and_alu", 16'({alu_sel, alu_in_a_sel}), 16'b010);
      tick();

      // NOT
      to_exec(16'h927F);
      check("not_alu", 16'(alu_sel), 16'd2);
      check("not_wr", 16'({rf_w_wr, nzp_ld}), 16'b11);
      tick();

      // LDI R2,#3: 4 cycles
      to_exec(16'hA403);
      check("ldi_exec", 16'({temp_ld, dmem_rd, rf_w_wr}), 16'b110);
      check("ldi_raddr1", 16'(dmem_r_addr_sel), 16'd1);
      tick();
      check("ldi_exec2_state", 16'(state_dbg), 16'd4);
      check("ldi_raddr3", 16'(dmem_r_addr_sel), 16'd3);
      check("ldi_exec2_wr", 16'({dmem_rd, rf_w_wr, nzp_ld, temp_ld}), 16'b1110);
      check("ldi_wdata", 16'(rf_w_data_sel), 16'd1);
      tick();
      check("ldi_back_fetch", 16'(state_dbg), 16'd1);

      // LDR / ST / STR / LEA
      to_exec(16'h6283);
      check("ldr_raddr", 16'({dmem_rd, dmem_r_addr_sel}), 16'b110);
      tick();
      to_exec(16'h3205);
      check("st", 16'({dmem_wr, dmem_w_addr_sel, rf_w_wr}), 16'b1000);
      tick();
      to_exec(16'h7285);
      check("str", 16'({dmem_wr, dmem_w_addr_sel}), 16'b101);
      tick();
      to_exec(16'hE20A);
      check("lea", 16'({rf_w_wr, nzp_ld, rf_w_data_sel}), 16'b1111);
      tick();

      // BR not taken, then taken
      nzp_match = 1'b0;
      to_exec(16'h0402);
      check("br_nt_ld", 16'(pc_ld), 16'd0);
      tick();
      nzp_match = 1'b1;
      to_exec(16'h0402);
      check("br_t_ld", 16'({pc_ld, pc_sel}), 16'b100);
      tick();
      nzp_match = 1'b0;

      // JSR / JSRR / JMP
      to_exec(16'h4805);
      check("jsr", 16'({rf_w_addr_sel, rf_w_data_sel, pc_sel, pc_ld, rf_w_wr}), 16'b1100111);
      tick();
      to_exec(16'h41C0);
      check("jsrr", 16'({pc_sel, rf_rp_addr_sel, pc_ld, rf_w_addr_sel}), 16'b100111);
      tick();
      to_exec(16'hC1C0);
      check("jmp", 16'({pc_sel, rf_rp_addr_sel, pc_ld, rf_w_wr}), 16'b100110);
      tick();
      check("jmp_back_fetch", 16'(state_dbg), 16'd1);

      // STI; reset lands mid-EXEC2
      to_exec(16'hB203);
      check("sti_exec", 16'({temp_ld, dmem_rd, dmem_r_addr_sel, dmem_wr}), 16'b11010);
      tick();
      check("sti_exec2", 16'({state_dbg, dmem_wr, dmem_w_addr_sel, rf_rp_addr_sel}), 16'b10011000);
      rst = 1'b0;
      tick();
      check("rst_in_exec2", 16'(state_dbg), 16'd0);
      rst = 1'b1;
      tick();
      check("refetch", 16'(state_dbg), 16'd1);

      // Reserved opcode
      to_exec(16'h8000);
`ifdef PUNC_RESERVED_HALT_EN
      check("rsv_halt", 16'({state_dbg, halted}), 16'b1011);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
`else
      check("rsv_nop_state", 16'(state_dbg), 16'd3);
      check("rsv_nop_strobes", 16'({rf_w_wr, dmem_rd, dmem_wr, pc_ld, nzp_ld, temp_ld}), 16'd0);
      tick();
`endif
      check("rsv_fetch", 16'(state_dbg), 16'd1);

      // TRAP -> HALT two cycles after FETCH, absorbing until reset
      to_exec(16'hF025);
      check("trap_halt", 16'({state_dbg, halted}), 16'b1011);
      tick(); tick();
      check("halt_stays", 16'({state_dbg, halted}), 16'b1011);
      rst = 1'b0;
      tick();
      check("halt_rst", 16'({state_dbg, halted}), 16'b0000);
      rst = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
